// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the fetch stage.
package rv_fetch_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
   localparam logic [31:0] ECALL_INSTR  = 32'h0000_0073;
   localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

   localparam logic [1:0] FAULT_NONE     = 2'b00;
   localparam logic [1:0] FAULT_MISALIGN = 2'b01;
   localparam logic [1:0] FAULT_RANGE    = 2'b10;

   function automatic logic is_halt_instr(input logic [31:0] word);
      return (word == ECALL_INSTR) || (word == EBREAK_INSTR);
   endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC candidate: redirect/sequential select plus legality checks.
module fetch_next_pc
   import rv_fetch_pkg::*;
#(
   parameter int unsigned IMEM_DEPTH = 32
) (
   input  logic [31:0] pc_i,
   input  logic        use_redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] pc_plus4_o,
   output logic [31:0] cand_o,
   output logic        misaligned_o,
   output logic        out_of_range_o
);

   localparam logic [31:0] PC_LIMIT = 32'(IMEM_DEPTH) << 2;

   assign pc_plus4_o     = pc_i + 32'd4;
   assign cand_o         = use_redirect_i ? redirect_pc_i : pc_plus4_o;
   assign misaligned_o   = |cand_o[1:0];
   // Wrapped pc+4 lands at zero only from the top of the address space, which is already out of range.
   assign out_of_range_o = (cand_o >= PC_LIMIT);

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, issues word addresses to instruction memory and gates the returned word.
module inst_fetch_unit
   import rv_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_DEPTH = 32
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        resume,
   input  logic [31:0] instruct,
   output logic [31:0] imem_addr,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] inst_out,
   output logic        inst_valid,
   output logic        halted,
   output logic [1:0]  fault,
   output logic [31:0] retired_count
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [1:0]   fault_q, fault_d;
   logic [31:0]  count_q, count_d;

   logic [31:0]  cand;
   logic         misaligned;
   logic         outOfRange;
   logic         useRedirect;

   // Redirects only matter while running; in HALT the candidate is always pc+4.
   assign useRedirect = redirect && (state_q == RUN);

   fetch_next_pc #(
      .IMEM_DEPTH (IMEM_DEPTH)
   ) u_next_pc (
      .pc_i           (pc_q),
      .use_redirect_i (useRedirect),
      .redirect_pc_i  (redirect_pc),
      .pc_plus4_o     (pc_plus4),
      .cand_o         (cand),
      .misaligned_o   (misaligned),
      .out_of_range_o (outOfRange)
   );

   assign imem_addr     = {2'b00, pc_q[31:2]};
   assign pc            = pc_q;
   assign inst_valid    = (state_q == RUN);
   assign halted        = (state_q == HALT);
   assign inst_out      = inst_valid ? instruct : NOP_INSTR;
   assign fault         = fault_q;
   assign retired_count = count_q;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      fault_d = fault_q;
      count_d = count_q;
      case (state_q)
         BOOT: state_d = RUN;
         RUN: begin
            if (!stall) begin
               count_d = count_q + 32'd1;
               if (is_halt_instr(instruct)) begin
                  state_d = HALT;
               end else if (misaligned) begin
                  fault_d = FAULT_MISALIGN;
                  state_d = HALT;
               end else if (outOfRange) begin
                  fault_d = FAULT_RANGE;
                  state_d = HALT;
               end else begin
                  pc_d = cand;
               end
            end
         end
         HALT: begin
            // Only a clean halt can be resumed; faults stay until reset.
            if (resume && (fault_q == FAULT_NONE)) begin
               if (misaligned) begin
                  fault_d = FAULT_MISALIGN;
               end else if (outOfRange) begin
                  fault_d = FAULT_RANGE;
               end else begin
                  pc_d    = cand;
                  state_d = RUN;
               end
            end
         end
         default: state_d = BOOT;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         fault_q <= FAULT_NONE;
         count_q <= 32'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         fault_q <= fault_d;
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios then random traffic against a behavioural model.
module tb_inst_fetch_unit;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        resume;
   logic [31:0] instruct;
   logic [31:0] imem_addr;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] inst_out;
   logic        inst_valid;
   logic        halted;
   logic [1:0]  fault;
   logic [31:0] retired_count;

   logic [31:0] mem [32];

   // Behavioural model of the fetch stage
   logic [31:0] mPc;
   logic        mBooting;
   logic        mHalted;
   logic [1:0]  mFault;
   logic [31:0] mCount;

   int errors = 0;
   int checks = 0;

   inst_fetch_unit #(
      .RESET_PC   (32'h0000_0000),
      .IMEM_DEPTH (32)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .stall         (stall),
      .redirect      (redirect),
      .redirect_pc   (redirect_pc),
      .resume        (resume),
      .instruct      (instruct),
      .imem_addr     (imem_addr),
      .pc            (pc),
      .pc_plus4      (pc_plus4),
      .inst_out      (inst_out),
      .inst_valid    (inst_valid),
      .halted        (halted),
      .fault         (fault),
      .retired_count (retired_count)
   );

   always #5 clock = ~clock;

   assign instruct = mem[imem_addr[4:0]];

   task automatic applyStimulus(input logic rn, input logic st, input logic rd,
                                input logic [31:0] rpc, input logic rs);
      reset_n     = rn;
      stall       = st;
      redirect    = rd;
      redirect_pc = rpc;
      resume      = rs;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit isHaltWord(input logic [31:0] w);
      return (w == 32'h0000_0073) || (w == 32'h0010_0073);
   endfunction

   // A target is acceptable when word aligned and inside the 128-byte memory.
   function automatic logic [1:0] targetFault(input logic [31:0] t);
      if ((t % 4) != 0) return 2'b01;
      if (t >= 32'd128) return 2'b10;
      return 2'b00;
   endfunction

   task automatic modelStep();
      logic [31:0] nxt;
      if (!reset_n) begin
         mPc = 32'h0; mBooting = 1'b1; mHalted = 1'b0; mFault = 2'b00; mCount = 32'h0;
      end else if (mBooting) begin
         mBooting = 1'b0;
      end else if (mHalted) begin
         if (resume && mFault == 2'b00) begin
            nxt = mPc + 32'd4;
            if (targetFault(nxt) != 2'b00) mFault = targetFault(nxt);
            else begin mPc = nxt; mHalted = 1'b0; end
         end
      end else if (!stall) begin
         mCount = mCount + 32'd1;
         if (isHaltWord(mem[mPc / 4])) begin
            mHalted = 1'b1;
         end else begin
            nxt = redirect ? redirect_pc : mPc + 32'd4;
            if (targetFault(nxt) != 2'b00) begin
               mFault  = targetFault(nxt);
               mHalted = 1'b1;
            end else begin
               mPc = nxt;
            end
         end
      end
   endtask

   task automatic checkAll();
      logic running;
      running = !mBooting && !mHalted;
      checkOutput("pc", pc, mPc);
      checkOutput("imem_addr", imem_addr, mPc / 4);
      checkOutput("pc_plus4", pc_plus4, mPc + 32'd4);
      checkOutput("inst_valid", {31'b0, inst_valid}, {31'b0, running});
      checkOutput("inst_out", inst_out, running ? mem[mPc / 4] : 32'h0000_0013);
      checkOutput("halted", {31'b0, halted}, {31'b0, mHalted});
      checkOutput("fault", {30'b0, fault}, {30'b0, mFault});
      checkOutput("retired_count", retired_count, mCount);
   endtask

   task automatic tick();
      @(posedge clock);
      modelStep();
      #1;
      checkAll();
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h0000_0093 | (32'(i) << 20);
      mem[3] = 32'h0000_0073;
      mPc = 32'h0; mBooting = 1'b1; mHalted = 1'b0; mFault = 2'b00; mCount = 32'h0;

      // Scenario 1: reset, boot, sequential fetch, reset mid-run
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
      checkOutput("t1_boot_valid", {31'b0, inst_valid}, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
      checkOutput("t1_run_pc0", pc, 32'h0);
      tick();
      tick();
      checkOutput("t1_pc8", pc, 32'h8);
      checkOutput("t1_addr2", imem_addr, 32'd2);
      checkOutput("t1_count2", retired_count, 32'd2);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
      checkOutput("t1_reset_pc", pc, 32'h0);
      checkOutput("t1_reset_count", retired_count, 32'h0);

      // Scenario 2: redirect from pc=4 to 0x10
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
      tick();
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h10, 1'b0);
      tick();
      checkOutput("t2_pc", pc, 32'h10);
      checkOutput("t2_addr", imem_addr, 32'd4);
      checkOutput("t2_plus4", pc_plus4, 32'h14);

      // Scenario 3: stall overrides redirect at pc=8
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h8, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h20, 1'b0);
      for (int i = 0; i < 3; i++) tick();
      checkOutput("t3_stall_pc", pc, 32'h8);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
      checkOutput("t3_pcC", pc, 32'hC);

      // Scenario 4: ECALL halts, redirect ignored in HALT, resume continues
      checkOutput("t4_ecall_out", inst_out, 32'h0000_0073);
      tick();
      checkOutput("t4_halted", {31'b0, halted}, 32'h1);
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h40, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      tick();
      checkOutput("t4_resume_pc", pc, 32'h10);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

      // Scenario 5: misaligned redirect is sticky until reset
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h6, 1'b0);
      tick();
      checkOutput("t5_fault", {30'b0, fault}, 32'h1);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      tick();
      checkOutput("t5_still_halted", {31'b0, halted}, 32'h1);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
      checkOutput("t5_cleared", {30'b0, fault}, 32'h0);

      // Scenario 6: run off the end of memory
      for (int i = 0; i < 80; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, mHalted && (mFault == 2'b00));
         tick();
         if (mFault != 2'b00) break;
      end
      checkOutput("t6_fault", {30'b0, fault}, 32'h2);
      checkOutput("t6_pc", pc, 32'h7C);
      checkOutput("t6_addr", imem_addr, 32'd31);

      // Random traffic
      for (int i = 0; i < 32; i++) begin
         case ($urandom_range(0, 11))
            0:       mem[i] = 32'h0000_0073;
            1:       mem[i] = 32'h0010_0073;
            default: mem[i] = ($urandom & 32'hFFFF_FF80) | 32'h13;
         endcase
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
      for (int i = 0; i < 600; i++) begin
         logic        rn, st, rd, rs;
         logic [31:0] rpc;
         rn = !((mFault != 2'b00) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 59) == 0));
         st = ($urandom_range(0, 4) == 0);
         rd = ($urandom_range(0, 5) == 0);
         rs = mHalted ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
         case ($urandom_range(0, 9))
            6:       rpc = {$urandom_range(0, 31), 2'b00} | 32'($urandom_range(1, 3));
            7:       rpc = 32'h80;
            8:       rpc = 32'h7C;
            9:       rpc = $urandom;
            default: rpc = 32'($urandom_range(0, 31)) << 2;
         endcase
         applyStimulus(rn, st, rd, rpc, rs);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
